// File: rtl/icache_direct_pkg.sv
// Shared types and constants for the direct-mapped instruction cache:
// line geometry, refill FSM encoding and the zero word returned on non-hits.
package icache_direct_pkg;

  localparam int          LINE_WORDS = 4;
  localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_e;

  // True when the given word offset is the final word of a line.
  function automatic logic is_last_word(input logic [1:0] word);
    return (word == 2'(LINE_WORDS - 1));
  endfunction

endpackage

// File: rtl/icache_direct_if.sv
// Fetch-side and refill-side signals of the instruction cache. The cache
// itself uses the slave view; the core/memory environment uses the master view.
interface icache_direct_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  ce_i;
  logic [ADDR_WIDTH-1:0] addr_i;
  logic [31:0]           data_o;
  logic                  stall_o;
  logic                  flush_i;
  logic                  mem_req_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic                  mem_ack_i;
  logic [31:0]           mem_data_i;

  modport slave (
    input  ce_i, addr_i, flush_i, mem_ack_i, mem_data_i,
    output data_o, stall_o, mem_req_o, mem_addr_o
  );

  modport master (
    output ce_i, addr_i, flush_i, mem_ack_i, mem_data_i,
    input  data_o, stall_o, mem_req_o, mem_addr_o
  );
endinterface

// File: rtl/icache_tag_ram.sv
// Valid/tag store for the direct-mapped cache: one combinational read port,
// one write port and a clear-all that invalidates every line.
module icache_tag_ram
  import icache_direct_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 22
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_all,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic                  wr_valid
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]    valid_r;
  logic [TAG_BITS-1:0] tag_r [LINES];

  // Valid bits; a clear-all wins over a concurrent line write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_r <= '0;
    end else if (clear_all) begin
      valid_r <= '0;
    end else if (wr_en) begin
      valid_r[wr_index] <= wr_valid;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Tag storage needs no reset: a line is only trusted once its valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_r[wr_index] <= wr_tag;
    end
  end

  assign rd_valid = valid_r[rd_index];
  assign rd_tag   = tag_r[rd_index];

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped instruction cache: same-cycle hits, 4-word line refill over a
// req/ack memory port, stall request to the core while a miss is serviced.
module icache_direct
  import icache_direct_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int ADDR_WIDTH = 32
) (
  input logic            clk,
  input logic            rst,
  icache_direct_if.slave bus
);

  localparam int TAG_BITS  = ADDR_WIDTH - 4 - INDEX_BITS;
  localparam int LINE_BITS = ADDR_WIDTH - 4;
  localparam int LINES     = 1 << INDEX_BITS;

  state_e                 state_r;
  state_e                 state_nxt_s;
  logic [LINE_BITS-1:0]   base_r;
  logic [1:0]             word_r;
  logic [1:0]             word_nxt_s;
  logic                   mem_req_r;
  logic [ADDR_WIDTH-1:0]  mem_addr_r;
  logic                   flush_pend_r;
  logic [31:0]            data_r [LINES*LINE_WORDS];

  logic [INDEX_BITS-1:0]  index_s;
  logic [TAG_BITS-1:0]    tag_s;
  logic                   tag_valid_s;
  logic [TAG_BITS-1:0]    tag_rd_s;
  logic                   hit_s;
  logic                   miss_s;
  logic                   ack_s;
  logic                   last_s;
  logic                   flush_eff_s;
  logic                   tag_wr_s;
  logic                   clear_all_s;
  logic [31:0]            data_s;
  logic                   stall_s;
  logic                   unused_s;

  assign index_s    = bus.addr_i[4+INDEX_BITS-1:4];
  assign tag_s      = bus.addr_i[ADDR_WIDTH-1:4+INDEX_BITS];
  assign word_nxt_s = word_r + 2'd1;
  assign unused_s   = ^bus.addr_i[1:0];

  icache_tag_ram #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_tag_ram (
    .clk       (clk),
    .rst       (rst),
    .clear_all (clear_all_s),
    .rd_index  (index_s),
    .rd_valid  (tag_valid_s),
    .rd_tag    (tag_rd_s),
    .wr_en     (tag_wr_s),
    .wr_index  (base_r[INDEX_BITS-1:0]),
    .wr_tag    (base_r[LINE_BITS-1:INDEX_BITS]),
    .wr_valid  (~flush_eff_s)
  );

  // Lookup, core-facing outputs and refill FSM next state.
  always_comb begin
    state_nxt_s = state_r;
    hit_s       = 1'b0;
    miss_s      = 1'b0;
    ack_s       = 1'b0;
    last_s      = 1'b0;
    flush_eff_s = 1'b0;
    tag_wr_s    = 1'b0;
    clear_all_s = 1'b0;
    data_s      = ZERO_WORD;
    stall_s     = 1'b0;
    case (state_r)
      IDLE: begin
        hit_s       = bus.ce_i & tag_valid_s & (tag_rd_s == tag_s);
        miss_s      = bus.ce_i & ~hit_s;
        clear_all_s = bus.flush_i;
        stall_s     = miss_s;
        if (hit_s) begin
          data_s = data_r[{index_s, bus.addr_i[3:2]}];
        end else begin
          data_s = ZERO_WORD;
        end
        if (miss_s) begin
          state_nxt_s = REFILL;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      REFILL: begin
        // A flush seen at any point of the refill, including the final ack,
        // keeps the new line invalid and wipes the whole cache at completion.
        stall_s     = 1'b1;
        ack_s       = mem_req_r & bus.mem_ack_i;
        last_s      = ack_s & is_last_word(word_r);
        flush_eff_s = flush_pend_r | bus.flush_i;
        tag_wr_s    = last_s;
        clear_all_s = last_s & flush_eff_s;
        if (last_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = REFILL;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Refill FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Refill sequencing: latched line, word counter, memory request and address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_r       <= '0;
      word_r       <= 2'd0;
      mem_req_r    <= 1'b0;
      mem_addr_r   <= '0;
      flush_pend_r <= 1'b0;
    end else if (miss_s) begin
      base_r       <= bus.addr_i[ADDR_WIDTH-1:4];
      word_r       <= 2'd0;
      mem_req_r    <= 1'b1;
      mem_addr_r   <= {bus.addr_i[ADDR_WIDTH-1:4], 4'h0};
      flush_pend_r <= 1'b0;
    end else if (state_r == REFILL) begin
      flush_pend_r <= flush_eff_s;
      if (ack_s) begin
        word_r <= word_nxt_s;
        if (last_s) begin
          mem_req_r <= 1'b0;
        end else begin
          mem_addr_r <= {base_r, word_nxt_s, 2'b00};
        end
      end
    end
  end

  // Line data capture; the data array is not reset.
  always_ff @(posedge clk) begin
    if (ack_s) begin
      data_r[{base_r[INDEX_BITS-1:0], word_r}] <= bus.mem_data_i;
    end
  end

  assign bus.data_o     = rst ? data_s : ZERO_WORD;
  assign bus.stall_o    = rst ? stall_s : 1'b0;
  assign bus.mem_req_o  = mem_req_r;
  assign bus.mem_addr_o = mem_addr_r;

endmodule
